// File: rtl/cpu_run_control_if.sv
// Board/CPU-facing signal bundle for the run controller: raw buttons, breakpoint
// setup and instruction pointer in; execute enable and run state out.
interface cpu_run_control_if;
    logic       turbo;
    logic       run_btn;
    logic       step_btn;
    logic       break_en;
    logic [7:0] break_addr;
    logic [7:0] ip;
    logic       go;
    logic [1:0] state;
    logic       halted;

    modport master (
        output turbo, run_btn, step_btn, break_en, break_addr, ip,
        input  go, state, halted
    );

    modport slave (
        input  turbo, run_btn, step_btn, break_en, break_addr, ip,
        output go, state, halted
    );
endinterface

// File: rtl/cpu_run_control.sv
// CPU run controller: slow-tick / turbo free running, single step, run/pause
// and an instruction-address breakpoint that can be stepped or run past.
module cpu_run_control #(
    parameter int TICK_MAX  = 12499999,
    parameter int DB_CYCLES = 250000,
    parameter bit START_RUN = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    cpu_run_control_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BREAK = 2'd3
    } state_t;

    localparam state_t RESET_STATE = START_RUN ? ST_RUN : ST_HALT;
    localparam int TICK_W = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
    localparam int DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_MAX);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);

    // Bit 0 = turbo, bit 1 = run button, bit 2 = step button
    logic [2:0] raw_in;
    logic [2:0] meta_q;
    logic [2:0] sync_q;
    logic       turbo_sync;

    assign raw_in     = {bus.step_btn, bus.run_btn, bus.turbo};
    assign turbo_sync = sync_q[0];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    meta_q[gi] <= 1'b0;
                    sync_q[gi] <= 1'b0;
                end else begin
                    meta_q[gi] <= raw_in[gi];
                    sync_q[gi] <= meta_q[gi];
                end
            end
        end
    endgenerate

    // Index 0 = run button, index 1 = step button
    logic [1:0] press_p;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_db
            logic            level_q;
            logic            pulse_q;
            logic [DB_W-1:0] cnt_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    level_q <= 1'b0;
                    pulse_q <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    pulse_q <= 1'b0;
                    if (sync_q[gi+1] == level_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        cnt_q   <= '0;
                        level_q <= sync_q[gi+1];
                        pulse_q <= sync_q[gi+1];
                    end else begin
                        cnt_q <= cnt_q + DB_W'(1);
                    end
                end
            end

            assign press_p[gi] = pulse_q;
        end
    endgenerate

    logic run_p;
    logic step_p;
    assign run_p  = press_p[0];
    assign step_p = press_p[1];

    logic [TICK_W-1:0] tick_q;
    logic [TICK_W-1:0] tick_d;
    logic              tick0;

    assign tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
    assign tick0  = (tick_q == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    state_t state_q;
    logic   halted_q;
    logic   skip_q;
    logic   issue;
    logic   bp_hit;
    logic   go_w;

    assign issue  = tick0 || turbo_sync;
    assign bp_hit = bus.break_en && (bus.ip == bus.break_addr) && !skip_q;
    assign go_w   = ((state_q == ST_RUN) && issue && !bp_hit) || (state_q == ST_STEP);

    // Run press wins over step and over a same-cycle breakpoint
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= RESET_STATE;
            halted_q <= !START_RUN;
            skip_q   <= 1'b0;
        end else begin
            if (go_w) begin
                skip_q <= 1'b0;
            end
            case (state_q)
                ST_HALT: begin
                    if (run_p) begin
                        state_q  <= ST_RUN;
                        halted_q <= 1'b0;
                    end else if (step_p) begin
                        state_q  <= ST_STEP;
                        halted_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (run_p) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else if (issue && bp_hit) begin
                        state_q  <= ST_BREAK;
                        halted_q <= 1'b1;
                    end
                end
                ST_STEP: begin
                    state_q  <= ST_HALT;
                    halted_q <= 1'b1;
                end
                ST_BREAK: begin
                    if (run_p) begin
                        state_q  <= ST_RUN;
                        halted_q <= 1'b0;
                        skip_q   <= 1'b1;
                    end else if (step_p) begin
                        state_q  <= ST_STEP;
                        halted_q <= 1'b0;
                        skip_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= RESET_STATE;
                    halted_q <= !START_RUN;
                end
            endcase
        end
    end

    assign bus.go     = go_w;
    assign bus.state  = state_q;
    assign bus.halted = halted_q;

endmodule

// File: tb/tb_cpu_run_control.sv
// Directed bench: a cycle-by-cycle vector table for a START_RUN=1 controller,
// plus hand-written reset sequences on a START_RUN=0 instance.
module tb_cpu_run_control;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    always #5 clk = ~clk;

    cpu_run_control_if bus_a ();
    cpu_run_control_if bus_b ();

    cpu_run_control #(.TICK_MAX(3), .DB_CYCLES(2), .START_RUN(1'b1)) dut_a (
        .clk_i (clk),
        .rst_i (rst_a),
        .bus   (bus_a)
    );

    cpu_run_control #(.TICK_MAX(3), .DB_CYCLES(2), .START_RUN(1'b0)) dut_b (
        .clk_i (clk),
        .rst_i (rst_b),
        .bus   (bus_b)
    );

    typedef struct {
        logic       turbo;
        logic       run_btn;
        logic       step_btn;
        logic       break_en;
        logic [7:0] ip;
        logic       exp_go;
        logic [1:0] exp_state;
    } vec_t;

    vec_t tv[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int n, input logic t, input logic r, input logic s,
                       input logic be, input logic [7:0] ip, input logic go,
                       input logic [1:0] st);
        vec_t v;
        v.turbo = t; v.run_btn = r; v.step_btn = s; v.break_en = be;
        v.ip = ip; v.exp_go = go; v.exp_state = st;
        for (int k = 0; k < n; k++) tv.push_back(v);
    endtask

    function automatic logic halted_of(input logic [1:0] st);
        return (st == 2'd0) || (st == 2'd3);
    endfunction

    task automatic chk_b(input string tag, input logic go, input logic [1:0] st);
        chk({tag, " go"}, {7'd0, bus_b.go}, {7'd0, go});
        chk({tag, " state"}, {6'd0, bus_b.state}, {6'd0, st});
        chk({tag, " halted"}, {7'd0, bus_b.halted}, {7'd0, halted_of(st)});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus_a.turbo = 0; bus_a.run_btn = 0; bus_a.step_btn = 0;
        bus_a.break_en = 0; bus_a.break_addr = 8'h05; bus_a.ip = 8'h00;
        bus_b.turbo = 0; bus_b.run_btn = 0; bus_b.step_btn = 0;
        bus_b.break_en = 0; bus_b.break_addr = 8'h05; bus_b.ip = 8'h00;

        // free-running slow cadence, then turbo on/off
        add(1, 0,0,0,0,8'h00, 1,2'd1);
        add(3, 0,0,0,0,8'h00, 0,2'd1);
        add(1, 0,0,0,0,8'h00, 1,2'd1);
        add(2, 1,0,0,0,8'h00, 0,2'd1);
        add(2, 1,0,0,0,8'h00, 1,2'd1);
        add(2, 0,0,0,0,8'h00, 1,2'd1);
        add(1, 0,0,0,0,8'h00, 0,2'd1);
        add(1, 0,0,0,0,8'h00, 1,2'd1);
        add(1, 0,0,0,0,8'h00, 0,2'd1);
        // breakpoint hit in turbo, step out of BREAK
        add(2, 1,0,0,1,8'h00, 0,2'd1);
        add(2, 1,0,0,1,8'h00, 1,2'd1);
        add(1, 1,0,0,1,8'h05, 0,2'd1);
        add(1, 1,0,0,1,8'h05, 0,2'd3);
        add(2, 1,0,1,1,8'h05, 0,2'd3);
        add(3, 1,0,0,1,8'h05, 0,2'd3);
        add(1, 1,0,0,1,8'h05, 1,2'd2);
        add(1, 1,0,0,1,8'h06, 0,2'd0);
        // run from HALT, re-break, run out of BREAK past the address
        add(2, 1,1,0,1,8'h06, 0,2'd0);
        add(3, 1,0,0,1,8'h06, 0,2'd0);
        add(1, 1,0,0,1,8'h06, 1,2'd1);
        add(1, 1,0,0,1,8'h05, 0,2'd1);
        add(2, 1,1,0,1,8'h05, 0,2'd3);
        add(3, 1,0,0,1,8'h05, 0,2'd3);
        add(1, 1,0,0,1,8'h05, 1,2'd1);
        add(1, 1,0,0,1,8'h06, 1,2'd1);
        // pause press lands on a breakpoint hit
        add(2, 1,1,0,1,8'h06, 1,2'd1);
        add(2, 1,0,0,1,8'h06, 1,2'd1);
        add(1, 1,0,0,1,8'h05, 0,2'd1);
        add(1, 1,0,0,1,8'h05, 0,2'd0);
        // glitch, clean step, held step
        add(1, 1,0,1,1,8'h05, 0,2'd0);
        add(5, 1,0,0,1,8'h05, 0,2'd0);
        add(2, 1,0,1,1,8'h05, 0,2'd0);
        add(3, 1,0,0,1,8'h05, 0,2'd0);
        add(1, 1,0,0,1,8'h05, 1,2'd2);
        add(1, 1,0,0,1,8'h05, 0,2'd0);
        add(5, 1,0,1,1,8'h05, 0,2'd0);
        add(1, 1,0,1,1,8'h05, 1,2'd2);
        add(5, 1,0,1,1,8'h05, 0,2'd0);
        add(4, 1,0,0,1,8'h05, 0,2'd0);

        repeat (3) cyc();
        chk("rstA go", {7'd0, bus_a.go}, 8'd1);
        chk("rstA state", {6'd0, bus_a.state}, 8'd1);
        chk("rstA halted", {7'd0, bus_a.halted}, 8'd0);
        chk_b("rstB", 1'b0, 2'd0);
        $display("reset check: A state=%0d go=%b, B state=%0d go=%b",
                 bus_a.state, bus_a.go, bus_b.state, bus_b.go);

        rst_a = 1'b0;
        for (int i = 0; i < tv.size(); i++) begin
            bus_a.turbo    = tv[i].turbo;
            bus_a.run_btn  = tv[i].run_btn;
            bus_a.step_btn = tv[i].step_btn;
            bus_a.break_en = tv[i].break_en;
            bus_a.ip       = tv[i].ip;
            #1;
            $display("row %0d: go=%b state=%0d halted=%b (want go=%b state=%0d)",
                     i, bus_a.go, bus_a.state, bus_a.halted, tv[i].exp_go, tv[i].exp_state);
            chk($sformatf("row%0d go", i), {7'd0, bus_a.go}, {7'd0, tv[i].exp_go});
            chk($sformatf("row%0d state", i), {6'd0, bus_a.state}, {6'd0, tv[i].exp_state});
            chk($sformatf("row%0d halted", i), {7'd0, bus_a.halted},
                {7'd0, halted_of(tv[i].exp_state)});
            cyc();
        end

        // reset asserted while in STEP
        rst_b = 1'b0;
        bus_b.step_btn = 1'b1;
        chk_b("B idle", 1'b0, 2'd0);
        cyc();
        cyc();
        bus_b.step_btn = 1'b0;
        repeat (3) cyc();
        #1;
        chk_b("B step", 1'b1, 2'd2);
        $display("B step: go=%b state=%0d", bus_b.go, bus_b.state);
        rst_b = 1'b1;
        #1;
        chk_b("B rst mid-step", 1'b0, 2'd0);
        $display("B reset mid-step: go=%b state=%0d", bus_b.go, bus_b.state);
        cyc();
        cyc();
        rst_b = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk_b($sformatf("B after step rst %0d", i), 1'b0, 2'd0);
            cyc();
        end

        // reset asserted mid-debounce
        bus_b.step_btn = 1'b1;
        cyc();
        cyc();
        bus_b.step_btn = 1'b0;
        cyc();
        rst_b = 1'b1;
        #1;
        chk_b("B rst mid-debounce", 1'b0, 2'd0);
        cyc();
        rst_b = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk_b($sformatf("B after db rst %0d", i), 1'b0, 2'd0);
            cyc();
        end
        $display("B debounce reset: go=%b state=%0d", bus_b.go, bus_b.state);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
